// File: rtl/sonar_sensor_emulador.sv
// Ultrasonic sonar sensor emulator: measures the trigger width, waits a fixed delay,
// then produces an echo whose width encodes the latched distance, followed by a dead time.
module sonar_sensor_emulador #(
  parameter int CICLOS_TRIGGER_MIN = 500,
  parameter int CICLOS_ATRASO      = 20000,
  parameter int CICLOS_POR_CM      = 2941,
  parameter int DIST_MAX           = 400,
  parameter int CICLOS_TIMEOUT     = 1900000,
  parameter int CICLOS_REPOUSO     = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic       medida_aceita,
  output logic [3:0] db_estado
);

  localparam int WW    = $clog2(CICLOS_TRIGGER_MIN + 1);
  localparam int KW    = $clog2(CICLOS_POR_CM + 1);
  localparam int TMAX1 = (CICLOS_ATRASO > CICLOS_REPOUSO) ? CICLOS_ATRASO : CICLOS_REPOUSO;
  localparam int TMAX  = (CICLOS_TIMEOUT > TMAX1) ? CICLOS_TIMEOUT : TMAX1;
  localparam int TW    = ($clog2(TMAX + 1) > 21) ? $clog2(TMAX + 1) : 21;

  typedef enum logic [3:0] {
    ESPERA       = 4'd0,
    MEDE_TRIGGER = 4'd1,
    ATRASO       = 4'd2,
    ECO          = 4'd3,
    REPOUSO      = 4'd4
  } estado_t;

  estado_t         estado_q, estado_d;
  logic            trig_r_q;
  logic [WW-1:0]   largura_q, largura_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [KW-1:0]   tick_q, tick_d;
  logic [8:0]      cm_q, cm_d;
  logic [8:0]      dist_q, dist_d;
  logic            dist_valida;

  assign dist_valida = (dist_q != 9'd0) && ({23'd0, dist_q} <= 32'(DIST_MAX));

  always_comb begin
    estado_d      = estado_q;
    largura_d     = largura_q;
    timer_d       = timer_q;
    tick_d        = tick_q;
    cm_d          = cm_q;
    dist_d        = dist_q;
    medida_aceita = 1'b0;
    case (estado_q)
      ESPERA: begin
        if (trig_r_q) begin
          estado_d  = MEDE_TRIGGER;
          // restart the width count; this high cycle is already the first one
          largura_d = WW'(1);
        end
      end
      MEDE_TRIGGER: begin
        if (trig_r_q) begin
          if (largura_q < WW'(CICLOS_TRIGGER_MIN)) largura_d = largura_q + WW'(1);
        end else if (largura_q >= WW'(CICLOS_TRIGGER_MIN)) begin
          estado_d      = ATRASO;
          medida_aceita = 1'b1;
          dist_d        = distancia;
          timer_d       = '0;
        end else begin
          estado_d = ESPERA;
        end
      end
      ATRASO: begin
        if (timer_q == TW'(CICLOS_ATRASO - 1)) begin
          estado_d = ECO;
          timer_d  = '0;
          tick_d   = '0;
          cm_d     = dist_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ECO: begin
        // valid distances: one tick period per cm; otherwise a fixed timeout pulse
        if (dist_valida) begin
          if (tick_q == KW'(CICLOS_POR_CM - 1)) begin
            tick_d = '0;
            if (cm_q == 9'd1) begin
              estado_d = REPOUSO;
              timer_d  = '0;
            end else begin
              cm_d = cm_q - 9'd1;
            end
          end else begin
            tick_d = tick_q + KW'(1);
          end
        end else if (timer_q == TW'(CICLOS_TIMEOUT - 1)) begin
          estado_d = REPOUSO;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      REPOUSO: begin
        if (timer_q == TW'(CICLOS_REPOUSO - 1)) begin
          estado_d = ESPERA;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= ESPERA;
      trig_r_q  <= 1'b0;
      largura_q <= '0;
      timer_q   <= '0;
      tick_q    <= '0;
      cm_q      <= '0;
      dist_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      trig_r_q  <= trigger;
      largura_q <= largura_d;
      timer_q   <= timer_d;
      tick_q    <= tick_d;
      cm_q      <= cm_d;
      dist_q    <= dist_d;
    end
  end

  assign echo      = (estado_q == ECO);
  assign ocupado   = (estado_q != ESPERA);
  assign db_estado = estado_q;

endmodule

// File: tb/tb_sonar_sensor_emulador.sv
// Scoreboard bench for sonar_sensor_emulador using shrunk timing parameters.
module tb_sonar_sensor_emulador;

  localparam int TMIN = 10;
  localparam int ATR  = 50;
  localparam int KCM  = 7;
  localparam int DMAX = 20;
  localparam int TOUT = 300;
  localparam int REP  = 40;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger;
  logic [8:0] distancia;
  logic       echo, ocupado, medida_aceita;
  logic [3:0] db_estado;

  sonar_sensor_emulador #(
    .CICLOS_TRIGGER_MIN(TMIN), .CICLOS_ATRASO(ATR), .CICLOS_POR_CM(KCM),
    .DIST_MAX(DMAX), .CICLOS_TIMEOUT(TOUT), .CICLOS_REPOUSO(REP)
  ) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .distancia(distancia),
    .echo(echo), .ocupado(ocupado), .medida_aceita(medida_aceita), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int got_q[$];
  int acc_cnt = 0;
  int eco_len = 0;
  logic eco_prev = 1'b0;
  int n_atr, n_eco, n_rep, t_rise, n_bad;
  bit tmo;

  always @(negedge clock) begin
    if (medida_aceita === 1'b1) acc_cnt++;
    if (echo === 1'b1) eco_len++;
    else if (eco_prev) begin
      got_q.push_back(eco_len);
      eco_len = 0;
    end
    eco_prev = (echo === 1'b1);
  end

  function automatic int model_width(input int d);
    return (d >= 1 && d <= DMAX) ? d * KCM : TOUT;
  endfunction

  task automatic pulse_trigger(input int w);
    trigger = 1'b1;
    repeat (w) @(negedge clock);
    trigger = 1'b0;
  endtask

  task automatic run_until_idle();
    n_atr = 0; n_eco = 0; n_rep = 0; t_rise = -1; n_bad = 0; tmo = 1'b1;
    for (int t = 1; t <= 3000; t++) begin
      @(negedge clock);
      if (db_estado == 4'd2) n_atr++;
      if (db_estado == 4'd3) n_eco++;
      if (db_estado == 4'd4) n_rep++;
      if (echo === 1'b1 && t_rise < 0) t_rise = t;
      if (db_estado != 4'd0 && ocupado !== 1'b1) n_bad++;
      if (db_estado == 4'd0) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; trigger = 1'b0; distancia = 9'd0;
    repeat (3) @(negedge clock);
    checks++; if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo: got %b expected 0", echo); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
    checks++; if (medida_aceita !== 1'b0) begin errors++; $display("FAIL reset_aceita: got %b expected 0", medida_aceita); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_valid_trigger();
    int a0, g, e;
    distancia = 9'd20;
    exp_q.push_back(model_width(20));
    a0 = acc_cnt;
    pulse_trigger(TMIN);
    run_until_idle();
    checks++; if (tmo) begin errors++; $display("FAIL valid_timeout: got stuck expected idle"); end
    checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL valid_aceita: got %0d expected 1", acc_cnt - a0); end
    checks++; if (n_atr !== ATR) begin errors++; $display("FAIL valid_atraso: got %0d expected %0d", n_atr, ATR); end
    checks++; if (t_rise < ATR || t_rise > ATR + 2) begin errors++; $display("FAIL valid_rise: got %0d expected %0d..%0d", t_rise, ATR, ATR + 2); end
    checks++; if (n_eco !== 140) begin errors++; $display("FAIL valid_eco_state: got %0d expected 140", n_eco); end
    checks++; if (n_rep !== REP) begin errors++; $display("FAIL valid_repouso: got %0d expected %0d", n_rep, REP); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL valid_ocupado: got %0d low cycles expected 0", n_bad); end
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL valid_width: got no pulse expected one"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL valid_width: got %0d expected %0d", g, e); end
    end
  endtask

  task automatic test_short_trigger();
    int a0;
    distancia = 9'd5;
    a0 = acc_cnt;
    pulse_trigger(TMIN - 1);
    run_until_idle();
    repeat (ATR + 10) @(negedge clock);
    checks++; if (tmo) begin errors++; $display("FAIL short_timeout: got stuck expected idle"); end
    checks++; if (acc_cnt !== a0) begin errors++; $display("FAIL short_aceita: got %0d expected %0d", acc_cnt, a0); end
    checks++; if (t_rise !== -1 || got_q.size() !== 0) begin errors++; $display("FAIL short_echo: got rise %0d pulses %0d expected none", t_rise, got_q.size()); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL short_estado: got %0d expected 0", db_estado); end
  endtask

  task automatic test_timeout();
    int dists[3] = '{0, 25, 511};
    int g, e;
    foreach (dists[i]) begin
      distancia = 9'(dists[i]);
      exp_q.push_back(model_width(dists[i]));
      pulse_trigger(TMIN + 3);
      run_until_idle();
      checks++; if (tmo) begin errors++; $display("FAIL timeout_idle d=%0d: got stuck expected idle", dists[i]); end
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL timeout_width d=%0d: got no pulse", dists[i]); end
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL timeout_width d=%0d: got %0d expected %0d", dists[i], g, e); end
      end
    end
  endtask

  task automatic test_dist_change();
    int g, e;
    distancia = 9'd1;
    exp_q.push_back(model_width(1));
    pulse_trigger(TMIN);
    fork
      run_until_idle();
      begin repeat (10) @(negedge clock); distancia = 9'd300; end
    join
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL change_width: got no pulse"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL change_width: got %0d expected %0d", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int a0, g, e;
    distancia = 9'd5;
    exp_q.push_back(model_width(5));
    a0 = acc_cnt;
    pulse_trigger(TMIN);
    fork
      run_until_idle();
      begin
        for (int i = 0; i < 200 && echo !== 1'b1; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        pulse_trigger(TMIN + 2);
      end
    join
    checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL b2b_aceita: got %0d expected 1", acc_cnt - a0); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", got_q.size()); end
    checks++; if (n_rep !== REP || n_bad !== 0) begin errors++; $display("FAIL b2b_repouso: got %0d rep %0d low expected %0d rep 0 low", n_rep, n_bad, REP); end
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL b2b_width: got no pulse"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL b2b_width: got %0d expected %0d", g, e); end
    end
    got_q.delete();
  endtask

  task automatic test_held_trigger();
    int a0, g, e;
    distancia = 9'd4;
    exp_q.push_back(model_width(4));
    a0 = acc_cnt;
    trigger = 1'b1;
    repeat (3 * TMIN) @(negedge clock);
    checks++; if (db_estado !== 4'd1 || acc_cnt !== a0) begin errors++; $display("FAIL held_wait: got state %0d aceitas %0d expected 1 and %0d", db_estado, acc_cnt, a0); end
    trigger = 1'b0;
    run_until_idle();
    checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL held_aceita: got %0d expected 1", acc_cnt - a0); end
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL held_width: got no pulse"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL held_width: got %0d expected %0d", g, e); end
    end
  endtask

  task automatic test_reset_mid_eco();
    int g, e;
    distancia = 9'd10;
    pulse_trigger(TMIN);
    for (int i = 0; i < 200 && echo !== 1'b1; i++) @(negedge clock);
    checks++; if (echo !== 1'b1) begin errors++; $display("FAIL rst_eco_start: got %b expected 1", echo); end
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (echo !== 1'b0 || db_estado !== 4'd0) begin errors++; $display("FAIL rst_eco_drop: got echo %b state %0d expected 0 0", echo, db_estado); end
    reset = 1'b0;
    repeat (REP / 2) @(negedge clock);
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rst_no_repouso: got %b expected 0", ocupado); end
    checks++;
    if (got_q.size() == 0) begin errors++; $display("FAIL rst_partial: got no pulse expected truncated"); end
    else begin
      g = got_q.pop_front();
      if (g >= model_width(10)) begin errors++; $display("FAIL rst_partial: got %0d expected below %0d", g, model_width(10)); end
    end
    distancia = 9'd3;
    exp_q.push_back(model_width(3));
    pulse_trigger(TMIN);
    run_until_idle();
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin errors++; $display("FAIL rst_after_width: got no pulse"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) begin errors++; $display("FAIL rst_after_width: got %0d expected %0d", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_valid_trigger();
    test_short_trigger();
    test_timeout();
    test_dist_change();
    test_back_to_back();
    test_held_trigger();
    test_reset_mid_eco();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sonar_sensor_emulador.md
SONAR_SENSOR_EMULADOR -- requirements
Module: sonar_sensor_emulador

Interface
REQ-001 The block SHALL have parameter CICLOS_TRIGGER_MIN, default 500, minimum valid trigger width in clock cycles (10 us at 50 MHz).
REQ-002 The block SHALL have parameter CICLOS_ATRASO, default 20000, delay in cycles from trigger acceptance to echo rise (400 us).
REQ-003 The block SHALL have parameter CICLOS_POR_CM, default 2941, echo cycles per centimetre (58.82 us).
REQ-004 The block SHALL have parameter DIST_MAX, default 400, largest valid distance in cm.
REQ-005 The block SHALL have parameter CICLOS_TIMEOUT, default 1900000, echo width in cycles for an invalid distance (38 ms).
REQ-006 The block SHALL have parameter CICLOS_REPOUSO, default 50000, dead time in cycles after echo fall (1 ms).
REQ-007 The block SHALL have port clock, input, 1 bit, single system clock, 50 MHz.
REQ-008 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-009 The block SHALL have port trigger, input, 1 bit, trigger from the sonar under test.
REQ-010 The block SHALL have port distancia, input, 9 bits, emulated distance in cm, unsigned binary.
REQ-011 The block SHALL have port echo, output, 1 bit, emulated echo pulse.
REQ-012 The block SHALL have port ocupado, output, 1 bit, high in every state except ESPERA.
REQ-013 The block SHALL have port medida_aceita, output, 1 bit, one-cycle pulse on trigger acceptance.
REQ-014 The block SHALL have port db_estado, output, 4 bits, state code.

Function
REQ-015 trigger SHALL be registered once (trig_r) before any use; all timing below refers to trig_r.
REQ-016 The FSM SHALL use these states and db_estado codes: ESPERA=0, MEDE_TRIGGER=1, ATRASO=2, ECO=3, REPOUSO=4; codes 5-15 are unused.
REQ-017 ESPERA: when trig_r=1, the FSM SHALL go to MEDE_TRIGGER and clear the width counter.
REQ-018 MEDE_TRIGGER: the width counter SHALL increment each cycle trig_r=1 and saturate at CICLOS_TRIGGER_MIN.
REQ-019 MEDE_TRIGGER, on the first cycle trig_r=0: if the count is >= CICLOS_TRIGGER_MIN, the FSM SHALL go to ATRASO, assert medida_aceita for exactly that cycle, and latch distancia into dist_reg; otherwise it SHALL return to ESPERA with no other output change.
REQ-020 A trigger held high indefinitely SHALL keep the FSM in MEDE_TRIGGER; acceptance occurs only on the fall.
REQ-021 ATRASO SHALL last exactly CICLOS_ATRASO cycles; echo SHALL rise on the cycle ECO is entered.
REQ-022 ECO: echo SHALL stay high for exactly dist_reg*CICLOS_POR_CM cycles when 1 <= dist_reg <= DIST_MAX, and for CICLOS_TIMEOUT cycles otherwise (dist_reg=0 or dist_reg>DIST_MAX).
REQ-023 Echo width SHALL be generated with a per-cm tick counter and a cm down-counter; no multiplier.
REQ-024 After echo falls, the FSM SHALL enter REPOUSO for exactly CICLOS_REPOUSO cycles and then return to ESPERA.
REQ-025 trigger activity in ATRASO, ECO or REPOUSO SHALL be ignored.
REQ-026 Changes on distancia after acceptance SHALL not affect the echo in progress.
REQ-027 A trigger already high when REPOUSO ends SHALL be measured from that cycle and SHALL count only the cycles it remains high.
REQ-028 Counters SHALL be sized so they do not wrap at the maximum parameter values: 21 bits for the timeout, 9 bits for the cm count.

Reset
REQ-029 While reset=1 at a clock edge: state=ESPERA, echo=0, ocupado=0, medida_aceita=0, db_estado=0, and all counters and dist_reg=0.
REQ-030 Reset SHALL take priority over every transition; reset during ECO SHALL drop echo on the next edge with no REPOUSO.

Verification
REQ-031 trigger high 10 us, distancia=100 -> medida_aceita pulses once; echo rises 400 us after the trigger falls (±2 cycles of sync) and stays high 294100 cycles (5882 us).
REQ-032 trigger high 5 us -> no medida_aceita, echo stays 0, db_estado returns to 0.
REQ-033 distancia=0, then distancia=450, each with a valid trigger -> echo width 1900000 cycles in both cases.
REQ-034 distancia=1, with distancia changed to 300 during ATRASO -> echo width 2941 cycles.
REQ-035 Second 10 us trigger issued during ECO -> ignored; exactly one echo pulse; ocupado stays high through REPOUSO.
REQ-036 reset asserted mid-ECO -> echo=0, db_estado=0 on the next edge; a new trigger is then served normally.
